// File: rtl/spdif_rx_pkg.sv
// Shared S/PDIF receive definitions: interval classes, preamble
// codes, slot indices and the interval classifier.
package spdif_rx_pkg;

    typedef enum logic [1:0] {
        CLS_S   = 2'd0,
        CLS_M   = 2'd1,
        CLS_L   = 2'd2,
        CLS_ERR = 2'd3
    } cls_t;

    typedef enum logic [1:0] {
        PRE_B    = 2'd0,
        PRE_M    = 2'd1,
        PRE_W    = 2'd2,
        PRE_NONE = 2'd3
    } pre_t;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int SLOT_AUX   = 4;
    localparam int SLOT_AUDIO = 8;
    localparam int SLOT_V     = 28;
    localparam int SLOT_U     = 29;
    localparam int SLOT_C     = 30;
    localparam int SLOT_P     = 31;

    // Bit positions inside the 28-bit payload word (slot 4 = bit 0).
    localparam int BIT_V = SLOT_V - SLOT_AUX;
    localparam int BIT_U = SLOT_U - SLOT_AUX;
    localparam int BIT_C = SLOT_C - SLOT_AUX;

    function automatic cls_t classify(
        input int n,
        input int th_sm,
        input int th_ml,
        input int th_max
    );
        if (n < th_sm)       return CLS_S;
        else if (n < th_ml)  return CLS_M;
        else if (n <= th_max) return CLS_L;
        return CLS_ERR;
    endfunction

    // Classes 2..4 of a preamble; the leading L is implied.
    function automatic pre_t pre_decode(
        input cls_t c1,
        input cls_t c2,
        input cls_t c3
    );
        pre_t p;
        p = PRE_NONE;
        unique case (1'b1)
            (c1 == CLS_S && c2 == CLS_S && c3 == CLS_L): p = PRE_B;
            (c1 == CLS_L && c2 == CLS_S && c3 == CLS_S): p = PRE_M;
            (c1 == CLS_M && c2 == CLS_S && c3 == CLS_M): p = PRE_W;
            default: p = PRE_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/spdif_rx_bmc.sv
// Biphase-mark front end: synchronizer, edge detect, interval
// counter and S/M/L classifier.
// Ports: clk, rst_n (sync, active-low), spdif (async line),
//        cls_stb/cls (classified interval), tmo (timeout pulse).
import spdif_rx_pkg::*;

module spdif_rx_bmc #(
    parameter int TH_SM  = 6,
    parameter int TH_ML  = 10,
    parameter int TH_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spdif,
    output logic       cls_stb,
    output logic [1:0] cls,
    output logic       tmo
);

    localparam int CW = $clog2(TH_MAX + 2);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_MAX = CW'(TH_MAX);
    localparam logic [CW-1:0] C_SAT = CW'(TH_MAX + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic          w_edge;
    cls_t          w_cls;

    assign w_edge = r_sync2 ^ r_prev;
    assign w_cls  = classify(32'(r_cnt), TH_SM, TH_ML, TH_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_cnt   <= '0;
            cls_stb <= 1'b0;
            cls     <= 2'd0;
            tmo     <= 1'b0;
        end else begin
            r_sync1 <= spdif;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            cls_stb <= 1'b0;
            tmo     <= 1'b0;
            if (w_edge) begin
                // r_cnt holds the cycles since the previous edge.
                r_cnt   <= C_ONE;
                r_armed <= 1'b1;
                if (r_armed) begin
                    cls_stb <= 1'b1;
                    cls     <= w_cls;
                end
            end else begin
                if (r_cnt != C_SAT) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                // Timeout fires as the counter steps past TH_MAX;
                // the next edge then only re-arms timing.
                if (r_armed && r_cnt == C_MAX) begin
                    tmo     <= 1'b1;
                    r_armed <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/spdif_rx.sv
// S/PDIF receiver: preamble/slot FSM, payload shift register,
// parity check, lock tracking and output registers.
// Ports: clk, rst_n (sync, active-low), spdif (async line),
//        out_data/chan/blk/v/u/c/perr valid on out_stb, locked.
import spdif_rx_pkg::*;

module spdif_rx #(
    parameter int TH_SM  = 6,
    parameter int TH_ML  = 10,
    parameter int TH_MAX = 15,
    parameter int LOCK_N = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spdif,
    output logic [23:0] out_data,
    output logic        out_chan,
    output logic        out_blk,
    output logic        out_v,
    output logic        out_u,
    output logic        out_c,
    output logic        out_perr,
    output logic        out_stb,
    output logic        locked
);

    localparam int GW = $clog2(LOCK_N + 1);
    localparam logic [GW-1:0] G_MAX   = GW'(LOCK_N);
    localparam logic [4:0]    S_FIRST = 5'(SLOT_AUX);
    localparam logic [4:0]    S_LAST  = 5'(SLOT_P);

    logic        w_cls_stb;
    logic [1:0]  w_cls_raw;
    logic        w_tmo;
    cls_t        w_cls;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_pcnt;
    cls_t        r_c1;
    cls_t        r_c2;
    pre_t        r_pre;
    logic [4:0]  r_slot;
    logic        r_half;
    logic [26:0] r_sr;
    logic [GW-1:0] r_good;

    logic        w_err;
    logic        w_pre_ok;
    logic        w_bit_en;
    logic        w_bit;
    logic        w_half_nxt;
    logic        w_done;
    logic        w_perr;
    pre_t        w_pre;
    logic [27:0] w_word;
    logic [GW-1:0] w_good_inc;

    spdif_rx_bmc #(
        .TH_SM  (TH_SM),
        .TH_ML  (TH_ML),
        .TH_MAX (TH_MAX)
    ) u_bmc (
        .clk     (clk),
        .rst_n   (rst_n),
        .spdif   (spdif),
        .cls_stb (w_cls_stb),
        .cls     (w_cls_raw),
        .tmo     (w_tmo)
    );

    assign w_cls      = cls_t'(w_cls_raw);
    assign w_pre      = pre_decode(r_c1, r_c2, w_cls);
    assign w_word     = {w_bit, r_sr};
    assign w_perr     = ^w_word;
    assign w_good_inc = (r_good == G_MAX) ? G_MAX : r_good + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_HUNT: begin
                if (w_cls_stb && w_cls == CLS_L) begin
                    w_state_nxt = ST_PRE;
                end
            end
            ST_PRE: begin
                if (w_err) begin
                    w_state_nxt = ST_HUNT;
                end else if (w_pre_ok) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                // The edge closing slot 31 opens the next preamble.
                if (w_err || w_done) begin
                    w_state_nxt = ST_HUNT;
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    // Per-interval decode events.
    always_comb begin
        w_err      = 1'b0;
        w_pre_ok   = 1'b0;
        w_bit_en   = 1'b0;
        w_bit      = 1'b0;
        w_half_nxt = r_half;
        if (w_tmo) begin
            w_err = 1'b1;
        end else if (w_cls_stb) begin
            unique case (r_state)
                ST_PRE: begin
                    if (r_pcnt == 2'd2) begin
                        if (w_pre == PRE_NONE) begin
                            w_err = 1'b1;
                        end else begin
                            w_pre_ok = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    unique case (w_cls)
                        CLS_S: begin
                            if (r_half) begin
                                w_bit_en   = 1'b1;
                                w_bit      = 1'b1;
                                w_half_nxt = 1'b0;
                            end else begin
                                w_half_nxt = 1'b1;
                            end
                        end
                        CLS_M: begin
                            if (r_half) begin
                                w_err = 1'b1;
                            end else begin
                                w_bit_en = 1'b1;
                            end
                        end
                        default: w_err = 1'b1;
                    endcase
                end
                default: ;
            endcase
        end
        w_done = w_bit_en && (r_slot == S_LAST);
    end

    // Datapath, lock and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pcnt   <= 2'd0;
            r_c1     <= CLS_S;
            r_c2     <= CLS_S;
            r_pre    <= PRE_B;
            r_slot   <= 5'd0;
            r_half   <= 1'b0;
            r_sr     <= '0;
            r_good   <= '0;
            out_data <= '0;
            out_chan <= 1'b0;
            out_blk  <= 1'b0;
            out_v    <= 1'b0;
            out_u    <= 1'b0;
            out_c    <= 1'b0;
            out_perr <= 1'b0;
            out_stb  <= 1'b0;
            locked   <= 1'b0;
        end else begin
            out_stb <= 1'b0;
            if (r_state == ST_HUNT) begin
                r_pcnt <= 2'd0;
            end
            if (w_cls_stb && r_state == ST_PRE) begin
                r_c1   <= r_c2;
                r_c2   <= w_cls;
                r_pcnt <= r_pcnt + 1'b1;
            end
            if (w_pre_ok) begin
                r_pre  <= w_pre;
                r_slot <= S_FIRST;
                r_half <= 1'b0;
            end
            if (w_cls_stb && r_state == ST_DATA) begin
                r_half <= w_half_nxt;
            end
            if (w_bit_en) begin
                r_sr <= w_word[27:1];
                if (r_slot != S_LAST) begin
                    r_slot <= r_slot + 1'b1;
                end
            end
            if (w_done) begin
                out_stb  <= 1'b1;
                out_data <= w_word[23:0];
                out_v    <= w_word[BIT_V];
                out_u    <= w_word[BIT_U];
                out_c    <= w_word[BIT_C];
                out_perr <= w_perr;
                out_chan <= (r_pre == PRE_W);
                out_blk  <= (r_pre == PRE_B);
            end
            if (w_err) begin
                r_good <= '0;
                locked <= 1'b0;
            end else if (w_done) begin
                if (w_perr) begin
                    r_good <= '0;
                end else begin
                    r_good <= w_good_inc;
                    if (w_good_inc == G_MAX) begin
                        locked <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spdif_rx.sv
// Directed bench for spdif_rx: table-driven subframe streams
// plus hand-written loss-of-signal timing sequence.
module tb_spdif_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spdif = 1'b0;
    logic [23:0] out_data;
    logic        out_chan;
    logic        out_blk;
    logic        out_v;
    logic        out_u;
    logic        out_c;
    logic        out_perr;
    logic        out_stb;
    logic        locked;

    spdif_rx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spdif    (spdif),
        .out_data (out_data),
        .out_chan (out_chan),
        .out_blk  (out_blk),
        .out_v    (out_v),
        .out_u    (out_u),
        .out_c    (out_c),
        .out_perr (out_perr),
        .out_stb  (out_stb),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        logic chan;
        logic blk;
        logic v;
        logic u;
        logic c;
        logic perr;
        logic lock;
    } cap_t;

    // pre: 0=B 1=M 2=W 3=bad (L,S,L,S); flip inverts P.
    typedef struct {
        int          pre;
        logic [23:0] data;
        logic        v;
        logic        u;
        logic        c;
        logic        flip;
        logic        e_chan;
        logic        e_blk;
        logic        e_perr;
        logic        e_lock;
    } vec_t;

    cap_t cap_q[$];
    cap_t mon_c;
    vec_t tab[$];
    int   n_stb   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   jit     = 1'b0;

    always @(negedge clk) begin
        if (out_stb === 1'b1) begin
            mon_c.data = out_data;
            mon_c.chan = out_chan;
            mon_c.blk  = out_blk;
            mon_c.v    = out_v;
            mon_c.u    = out_u;
            mon_c.c    = out_c;
            mon_c.perr = out_perr;
            mon_c.lock = locked;
            cap_q.push_back(mon_c);
            n_stb++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_cap(input string t, input cap_t a,
                           input vec_t e);
        chk({t, ".data"}, 32'(a.data), 32'(e.data));
        chk({t, ".chan"}, 32'(a.chan), 32'(e.e_chan));
        chk({t, ".blk"},  32'(a.blk),  32'(e.e_blk));
        chk({t, ".v"},    32'(a.v),    32'(e.v));
        chk({t, ".u"},    32'(a.u),    32'(e.u));
        chk({t, ".c"},    32'(a.c),    32'(e.c));
        chk({t, ".perr"}, 32'(a.perr), 32'(e.e_perr));
        chk({t, ".lock"}, 32'(a.lock), 32'(e.e_lock));
    endtask

    function automatic vec_t mkvec(
        input int pre, input logic [23:0] d,
        input logic v, input logic u, input logic c,
        input logic flip, input logic ch, input logic blk,
        input logic perr, input logic lk
    );
        vec_t r;
        r.pre = pre; r.data = d; r.v = v; r.u = u; r.c = c;
        r.flip = flip; r.e_chan = ch; r.e_blk = blk;
        r.e_perr = perr; r.e_lock = lk;
        return r;
    endfunction

    function automatic logic [27:0] mkword(input vec_t e);
        logic [26:0] b;
        b = {e.c, e.u, e.v, e.data};
        return {(^b) ^ e.flip, b};
    endfunction

    task automatic tx_iv(input int n);
        repeat (n) @(posedge clk);
        #1 spdif = ~spdif;
    endtask

    // k: 0=S 1=M 2=L
    task automatic tx_cls(input int k);
        int n;
        case (k)
            0:       n = jit ? int'($urandom_range(5, 3)) : 4;
            1:       n = jit ? int'($urandom_range(9, 7)) : 8;
            default: n = jit ? int'($urandom_range(13, 11)) : 12;
        endcase
        tx_iv(n);
    endtask

    task automatic tx_sub(input int pre, input logic [27:0] w);
        case (pre)
            0: begin tx_cls(2); tx_cls(0); tx_cls(0); tx_cls(2); end
            1: begin tx_cls(2); tx_cls(2); tx_cls(0); tx_cls(0); end
            2: begin tx_cls(2); tx_cls(1); tx_cls(0); tx_cls(1); end
            default: begin
                tx_cls(2); tx_cls(0); tx_cls(2); tx_cls(0);
            end
        endcase
        for (int i = 0; i < 28; i++) begin
            if (w[i]) begin
                tx_cls(0);
                tx_cls(0);
            end else begin
                tx_cls(1);
            end
        end
    endtask

    task automatic tx_start();
        @(posedge clk);
        #1 spdif = ~spdif;
    endtask

    task automatic run_tab(input string tag);
        int e_n;
        int k;
        cap_q.delete();
        tx_start();
        foreach (tab[i]) tx_sub(tab[i].pre, mkword(tab[i]));
        repeat (40) @(posedge clk);
        @(negedge clk);
        e_n = 0;
        foreach (tab[i]) if (tab[i].pre != 3) e_n++;
        chk({tag, ".count"}, 32'(cap_q.size()), 32'(e_n));
        k = 0;
        foreach (tab[i]) begin
            if (tab[i].pre != 3) begin
                if (k < cap_q.size()) begin
                    chk_cap($sformatf("%s[%0d]", tag, i), cap_q[k],
                            tab[i]);
                end
                k++;
            end
        end
        chk({tag, ".idle_lock"}, 32'(locked), 32'd0);
    endtask

    initial begin
        int s0;
        int pre;
        logic [31:0] rd;
        logic [2:0] vuc;

        // Reset with a toggling line.
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (i % 4 == 3) spdif = ~spdif;
        end
        spdif = 1'b0;
        @(negedge clk);
        chk("rst.data", 32'(out_data), 32'd0);
        chk("rst.flags", 32'({out_chan, out_blk, out_v, out_u,
                              out_c, out_perr}), 32'd0);
        chk("rst.stb", 32'(out_stb), 32'd0);
        chk("rst.locked", 32'(locked), 32'd0);
        chk("rst.nstb", 32'(n_stb), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Lock, data, then parity error while locked.
        tab.delete();
        jit = 1'b0;
        tab.push_back(mkvec(0, 24'h123456, 0,1,1,0, 0,1,0,0));
        tab.push_back(mkvec(2, 24'hABCDEF, 0,1,1,0, 1,0,0,0));
        tab.push_back(mkvec(1, 24'h000001, 0,1,1,0, 0,0,0,0));
        tab.push_back(mkvec(2, 24'hFFFFFF, 0,1,1,0, 1,0,0,1));
        tab.push_back(mkvec(1, 24'h5A5A5A, 0,1,1,1, 0,0,1,1));
        tab.push_back(mkvec(2, 24'h00FF00, 0,1,1,0, 1,0,0,1));
        tab.push_back(mkvec(1, 24'h800000, 0,1,1,0, 0,0,0,1));
        tab.push_back(mkvec(2, 24'h13579B, 0,1,1,0, 1,0,0,1));
        run_tab("lock");

        // Jittered stream.
        tab.delete();
        jit = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pre = (i == 0) ? 0 : ((i % 2 == 1) ? 2 : 1);
            rd  = $urandom;
            vuc = 3'($urandom_range(7, 0));
            tab.push_back(mkvec(pre, rd[23:0], vuc[0], vuc[1],
                                vuc[2], 1'b0, pre == 2, pre == 0,
                                1'b0, i >= 3));
        end
        run_tab("jit");
        jit = 1'b0;

        // Loss of signal mid-DATA.
        cap_q.delete();
        tab.delete();
        tab.push_back(mkvec(0, 24'h0A0B0C, 0,0,0,0, 0,1,0,0));
        tab.push_back(mkvec(2, 24'h0D0E0F, 0,0,0,0, 1,0,0,0));
        tab.push_back(mkvec(1, 24'h102030, 0,0,0,0, 0,0,0,0));
        tab.push_back(mkvec(2, 24'h405060, 0,0,0,0, 1,0,0,1));
        tab.push_back(mkvec(1, 24'h708090, 0,0,0,0, 0,0,0,1));
        tx_start();
        foreach (tab[i]) tx_sub(tab[i].pre, mkword(tab[i]));
        tx_cls(2); tx_cls(1); tx_cls(0); tx_cls(1);
        for (int i = 0; i < 10; i++) tx_cls(1);
        s0 = n_stb;
        repeat (18) @(posedge clk);
        @(negedge clk);
        chk("loss.lock_hold", 32'(locked), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("loss.lock_drop", 32'(locked), 32'd0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("loss.no_stb", 32'(n_stb), 32'(s0));
        chk("loss.count", 32'(cap_q.size()), 32'd5);
        if (cap_q.size() == 5) begin
            chk_cap("loss[4]", cap_q[4], tab[4]);
        end

        // Resume, relock, then a bad preamble.
        tab.delete();
        tab.push_back(mkvec(0, 24'h111111, 1,0,0,0, 0,1,0,0));
        tab.push_back(mkvec(2, 24'h222222, 0,1,0,0, 1,0,0,0));
        tab.push_back(mkvec(1, 24'h333333, 0,0,1,0, 0,0,0,0));
        tab.push_back(mkvec(2, 24'h444444, 1,1,1,0, 1,0,0,1));
        tab.push_back(mkvec(3, 24'h555555, 0,0,0,0, 0,0,0,0));
        tab.push_back(mkvec(1, 24'h0F0F0F, 1,0,1,0, 0,0,0,0));
        run_tab("resume");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
